// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the streaming memory stages.
// Used by seq_mem_read_module and its output FIFO.
package mem_stage_pkg;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int LEN_W     = 32;
  localparam int DEF_STEP  = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } seq_rd_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] stride;
  } seq_rd_cmd_t;
endpackage

// File: rtl/seq_mem_read_module_fifo.sv
// sync_fifo_module: single-clock FIFO, power-of-two depth.
// Simultaneous push and pop leave the count unchanged.
module sync_fifo_module #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/seq_mem_read_module.sv
// Sequential memory reader feeding a FIFO; one read in flight at a time.
// Define SEQ_MEM_READ_STRIDE_EN to add a per-command cmd_stride_i port.
module seq_mem_read_module
  import mem_stage_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int data_width = DATA_W,
  parameter int len_width  = LEN_W,
  parameter int ADDR_STEP  = DEF_STEP,
  parameter int FIFO_DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] cmd_base_i,
  input  logic [len_width-1:0]  cmd_len_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
`ifdef SEQ_MEM_READ_STRIDE_EN
  input  logic [addr_width-1:0] cmd_stride_i,
`endif
  output logic                  mem_read,
  output logic [addr_width-1:0] mem_addr,
  input  logic                  mem_resp,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  valid_o,
  output logic [data_width-1:0] data_o,
  input  logic                  ready_i,
  output logic                  done_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_rd_state_e   r_state;
  seq_rd_state_e   w_state_n;
  seq_rd_cmd_t     w_cmd;
  logic [addr_width-1:0] r_addr;
  logic [addr_width-1:0] r_stride;
  logic [len_width-1:0]  r_rem;
  logic            r_inflight;
  logic            w_accept;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic            w_space;
  logic [CNT_W-1:0] w_count;

  always_comb begin
    w_cmd.base = cmd_base_i;
    w_cmd.len  = cmd_len_i;
`ifdef SEQ_MEM_READ_STRIDE_EN
    w_cmd.stride = cmd_stride_i;
`else
    w_cmd.stride = ADDR_W'(ADDR_STEP);
`endif
  end

  assign w_space  = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_accept = (r_state == IDLE) & cmd_valid_i;
  assign w_push   = (r_state == READ) & mem_read
                  & mem_resp & ~w_full;
  assign mem_addr = r_addr;
  assign valid_o  = ~w_empty;

  always_comb begin
    w_state_n   = r_state;
    cmd_ready_o = 1'b0;
    mem_read    = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready_o = ~rst;
        if (cmd_valid_i)
          w_state_n = (cmd_len_i == '0) ? DONE : READ;
      end
      READ: begin
        // a raised request is held until its response
        mem_read = r_inflight | w_space;
        if (mem_read && mem_resp && r_rem == len_width'(1))
          w_state_n = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= mem_read & ~mem_resp;
      if (w_accept) begin
        r_addr   <= w_cmd.base;
        r_rem    <= w_cmd.len;
        r_stride <= w_cmd.stride;
      end else if (w_push) begin
        r_addr <= r_addr + r_stride;
        r_rem  <= r_rem - 1'b1;
      end
    end
  end

  sync_fifo_module #(
    .WIDTH (data_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (mem_rdata),
    .i_pop   (ready_i),
    .o_rdata (data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_seq_mem_read_module.sv
// Directed bench for seq_mem_read_module with a 2-cycle memory model.
// Stride scenario runs only when SEQ_MEM_READ_STRIDE_EN is defined.
module tb_seq_mem_read_module;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cmd_base_i;
  logic [31:0] cmd_len_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
`ifdef SEQ_MEM_READ_STRIDE_EN
  logic [63:0] cmd_stride_i;
`endif
  logic        mem_read;
  logic [63:0] mem_addr;
  logic        mem_resp;
  logic [63:0] mem_rdata;
  logic        valid_o;
  logic [63:0] data_o;
  logic        ready_i;
  logic        done_o;

  int total = 0;
  int bad   = 0;
  int ndone = 0;
  int nrd   = 0;
  logic mem_en;
  logic inj;
  logic [63:0] alog[$];
  logic [63:0] outq[$];

  always #5 clk = ~clk;

  seq_mem_read_module dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_base_i  (cmd_base_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
`ifdef SEQ_MEM_READ_STRIDE_EN
    .cmd_stride_i(cmd_stride_i),
`endif
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .done_o      (done_o)
  );

  function automatic logic [63:0] dat(input logic [63:0] a);
    return a ^ 64'hA5A5_0000_5A5A_0000;
  endfunction

  initial begin
    int wcnt;
    wcnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        mem_resp = 1'b0;
      end else if (inj) begin
        mem_resp  = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (mem_read && mem_en) begin
        wcnt++;
        if (wcnt >= 2) begin
          mem_resp  = 1'b1;
          mem_rdata = dat(mem_addr);
          alog.push_back(mem_addr);
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (valid_o && ready_i) outq.push_back(data_o);
      if (done_o) ndone++;
      if (mem_read) nrd++;
    end
  end

  task automatic send_cmd(input logic [63:0] b, input logic [31:0] l,
                          input logic [63:0] s);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (!cmd_ready_o) begin
      bad++;
      $display("FAIL cmd_ready_timeout: got %b want 1", cmd_ready_o);
    end
    cmd_base_i  = b;
    cmd_len_i   = l;
`ifdef SEQ_MEM_READ_STRIDE_EN
    cmd_stride_i = s;
`else
    if (s != 64'd8) $display("note: stride %h ignored", s);
`endif
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (ndone == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ndone == d0) begin
      bad++;
      $display("FAIL done_timeout: got %0d pulses want 1", ndone - d0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cmd_ready_o !== 1'b0) begin
      bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready_o);
    end
    total++;
    if (mem_read !== 1'b0) begin
      bad++; $display("FAIL rst_mem_read: got %b want 0", mem_read);
    end
    total++;
    if (mem_addr !== 64'h0) begin
      bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr);
    end
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %b want 0", valid_o);
    end
    total++;
    if (data_o !== 64'h0) begin
      bad++; $display("FAIL rst_data: got %h want 0", data_o);
    end
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL rst_done: got %b want 0", done_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready_o);
    end
  endtask

  task automatic test_basic();
    int a0, o0, d0;
    logic [63:0] ea [3];
    ea[0] = 64'h100; ea[1] = 64'h108; ea[2] = 64'h110;
    ready_i = 1'b1;
    a0 = alog.size(); o0 = outq.size(); d0 = ndone;
    send_cmd(64'h100, 32'd3, 64'd8);
    total++;
    if (mem_read !== 1'b1 || mem_addr !== 64'h100) begin
      bad++;
      $display("FAIL basic_first_req: got %b/%h want 1/100",
               mem_read, mem_addr);
    end
    wait_done(d0);
    @(posedge clk);
    #1;
    total++;
    if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_len: got done=%b rdy=%b want 0/1",
               done_o, cmd_ready_o);
    end
    repeat (4) @(negedge clk);
    total++;
    if (alog.size() - a0 != 3) begin
      bad++; $display("FAIL basic_nreads: got %0d want 3", alog.size() - a0);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (alog[a0+i] !== ea[i]) begin
        bad++; $display("FAIL basic_addr%0d: got %h want %h",
                        i, alog[a0+i], ea[i]);
      end
      total++;
      if (outq[o0+i] !== dat(ea[i])) begin
        bad++; $display("FAIL basic_data%0d: got %h want %h",
                        i, outq[o0+i], dat(ea[i]));
      end
    end
    total++;
    if (ndone - d0 != 1) begin
      bad++; $display("FAIL basic_ndone: got %0d want 1", ndone - d0);
    end
  endtask

  task automatic test_len0();
    int r0, d0;
    r0 = nrd; d0 = ndone;
    send_cmd(64'h500, 32'd0, 64'd8);
    total++;
    if (done_o !== 1'b1) begin
      bad++; $display("FAIL len0_done: got %b want 1", done_o);
    end
    @(posedge clk);
    #1;
    total++;
    if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL len0_after: got done=%b rdy=%b want 0/1",
               done_o, cmd_ready_o);
    end
    repeat (3) @(negedge clk);
    total++;
    if (nrd != r0 || ndone - d0 != 1) begin
      bad++;
      $display("FAIL len0_noread: got rd=%0d done=%0d want 0/1",
               nrd - r0, ndone - d0);
    end
  endtask

  task automatic test_backpressure();
    int a0, o0, d0;
    ready_i = 1'b0;
    a0 = alog.size(); o0 = outq.size(); d0 = ndone;
    send_cmd(64'h200, 32'd6, 64'd8);
    repeat (40) @(negedge clk);
    total++;
    if (alog.size() - a0 != 4) begin
      bad++; $display("FAIL bp_nreads: got %0d want 4", alog.size() - a0);
    end
    total++;
    if (mem_read !== 1'b0 || valid_o !== 1'b1) begin
      bad++; $display("FAIL bp_stall: got rd=%b vld=%b want 0/1",
                      mem_read, valid_o);
    end
    total++;
    if (outq.size() != o0) begin
      bad++; $display("FAIL bp_nopop: got %0d want 0", outq.size() - o0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    wait_done(d0);
    repeat (6) @(negedge clk);
    total++;
    if (outq.size() - o0 != 6) begin
      bad++; $display("FAIL bp_nout: got %0d want 6", outq.size() - o0);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (alog[a0+i] !== 64'h200 + 64'(8*i) ||
          outq[o0+i] !== dat(64'h200 + 64'(8*i))) begin
        bad++; $display("FAIL bp_word%0d: got %h/%h want %h", i,
                        alog[a0+i], outq[o0+i], 64'h200 + 64'(8*i));
      end
    end
  endtask

  task automatic test_wrap();
    int a0, d0;
    ready_i = 1'b1;
    a0 = alog.size(); d0 = ndone;
    send_cmd(64'hFFFF_FFFF_FFFF_FFF8, 32'd2, 64'd8);
    wait_done(d0);
    repeat (3) @(negedge clk);
    total++;
    if (alog[a0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      bad++; $display("FAIL wrap_a0: got %h want fff..ff8", alog[a0]);
    end
    total++;
    if (alog[a0+1] !== 64'h0) begin
      bad++; $display("FAIL wrap_a1: got %h want 0", alog[a0+1]);
    end
  endtask

  task automatic test_reset_mid();
    int a0, o0, n;
    ready_i = 1'b0;
    a0 = alog.size();
    send_cmd(64'h300, 32'd4, 64'd8);
    n = 0;
    while (alog.size() - a0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    mem_en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (valid_o !== 1'b1 || mem_read !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got vld=%b rd=%b want 1/1",
                      valid_o, mem_read);
    end
    o0 = outq.size();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (valid_o !== 1'b0 || mem_read !== 1'b0 || data_o !== 64'h0) begin
      bad++; $display("FAIL mid_rst: got vld=%b rd=%b dat=%h want 0/0/0",
                      valid_o, mem_read, data_o);
    end
    rst = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || outq.size() != o0) begin
      bad++; $display("FAIL mid_late_resp: got vld=%b n=%0d want 0/0",
                      valid_o, outq.size() - o0);
    end
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL mid_idle: got %b want 1", cmd_ready_o);
    end
    mem_en = 1'b1;
  endtask

`ifdef SEQ_MEM_READ_STRIDE_EN
  task automatic test_stride();
    int a0, d0;
    ready_i = 1'b1;
    a0 = alog.size(); d0 = ndone;
    send_cmd(64'h0, 32'd3, 64'h40);
    wait_done(d0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (alog[a0+i] !== 64'(64*i)) begin
        bad++; $display("FAIL stride_a%0d: got %h want %h",
                        i, alog[a0+i], 64'(64*i));
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_base_i = '0;
    cmd_len_i = '0;
    cmd_valid_i = 1'b0;
`ifdef SEQ_MEM_READ_STRIDE_EN
    cmd_stride_i = 64'd8;
`endif
    ready_i = 1'b0;
    mem_en = 1'b1;
    inj = 1'b0;
    test_reset();
    test_basic();
    test_len0();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef SEQ_MEM_READ_STRIDE_EN
    test_stride();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
